// File: rtl/alu_decode_stage.sv
// ALU control decoder with ID/EX pipeline register, stall/flush handling and an
// optional illegal-op trap/counter enabled by defining ALU_ILLEGAL_TRAP_EN.
module alu_decode_stage #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [1:0]       ALUOp,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             op5,
  input  logic             stall,
  input  logic             flush,
  output logic             ex_valid,
  output logic [2:0]       ALUControl,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  logic [2:0] dec_ctrl;
  logic       load;

  assign load = !flush && !stall;

  // Unsupported encodings fall through to ADD so the EX stage always sees a defined op.
  always_comb begin
    dec_ctrl = ALU_ADD;
    case (ALUOp)
      2'b00: dec_ctrl = ALU_ADD;
      2'b01: dec_ctrl = ALU_SUB;
      2'b10: begin
        case (funct3)
          3'b000:  dec_ctrl = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  dec_ctrl = ALU_SLT;
          3'b100:  dec_ctrl = ALU_XOR;
          3'b110:  dec_ctrl = ALU_OR;
          3'b111:  dec_ctrl = ALU_AND;
          default: dec_ctrl = ALU_ADD;
        endcase
      end
      default: dec_ctrl = ALU_ADD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid   <= 1'b0;
      ALUControl <= ALU_ADD;
    end else if (flush) begin
      ex_valid   <= 1'b0;
      ALUControl <= ALU_ADD;
    end else if (!stall) begin
      ex_valid   <= id_valid;
      ALUControl <= id_valid ? dec_ctrl : ALU_ADD;
    end
  end

`ifdef ALU_ILLEGAL_TRAP_EN
  logic             dec_illegal;
  logic             ill_q;
  logic [CNT_W-1:0] cnt_q;

  always_comb begin
    dec_illegal = 1'b0;
    if (ALUOp == 2'b11)
      dec_illegal = 1'b1;
    else if (ALUOp == 2'b10 && (funct3 == 3'b001 || funct3 == 3'b011 || funct3 == 3'b101))
      dec_illegal = 1'b1;
  end

  // Counting only on a real load keeps a stalled illegal op from being counted twice.
  always_ff @(posedge clk) begin
    if (rst) begin
      ill_q <= 1'b0;
      cnt_q <= '0;
    end else if (flush) begin
      ill_q <= 1'b0;
    end else if (load) begin
      ill_q <= id_valid && dec_illegal;
      if (id_valid && dec_illegal && (cnt_q != {CNT_W{1'b1}}))
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign illegal     = ill_q;
  assign illegal_cnt = cnt_q;
`else
  assign illegal     = 1'b0;
  assign illegal_cnt = '0;
`endif

endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed testbench for alu_decode_stage; trap/counter checks follow ALU_ILLEGAL_TRAP_EN.
module tb_alu_decode_stage;

  logic       clk = 1'b0;
  logic       rst, id_valid, funct7b5, op5, stall, flush;
  logic [1:0] ALUOp;
  logic [2:0] funct3;
  logic       ex_valid, illegal;
  logic [2:0] ALUControl;
  logic [1:0] illegal_cnt;

  int checks = 0;
  int errors = 0;

  alu_decode_stage #(.CNT_W(2)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .ALUOp(ALUOp), .funct3(funct3),
    .funct7b5(funct7b5), .op5(op5), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ALUControl(ALUControl), .illegal(illegal),
    .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [2:0] f3,
                       input logic f7, input logic o5, input logic st, input logic fl);
    id_valid = v; ALUOp = op; funct3 = f3; funct7b5 = f7; op5 = o5; stall = st; flush = fl;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 2'b01, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    checks += 3;
    if (ex_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b exp 0", ex_valid); end
    if (ALUControl !== 3'b000) begin errors++; $display("[TB] FAIL reset_ctrl got %b exp 000", ALUControl); end
    if (illegal !== 1'b0) begin errors++; $display("[TB] FAIL reset_illegal got %b exp 0", illegal); end
    checks++;
    if (illegal_cnt !== 2'd0) begin errors++; $display("[TB] FAIL reset_cnt got %0d exp 0", illegal_cnt); end
    rst = 1'b0;
  endtask

  task automatic test_sub_add();
    drive(1'b1, 2'b10, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    checks += 2;
    if (ALUControl !== 3'b001) begin errors++; $display("[TB] FAIL rtype_sub got %b exp 001", ALUControl); end
    if (ex_valid !== 1'b1) begin errors++; $display("[TB] FAIL rtype_sub_valid got %b exp 1", ex_valid); end
    op5 = 1'b0;
    step();
    checks++;
    if (ALUControl !== 3'b000) begin errors++; $display("[TB] FAIL itype_add got %b exp 000", ALUControl); end
  endtask

  task automatic test_funct_sweep();
    logic [2:0] f3s [4] = '{3'b010, 3'b100, 3'b110, 3'b111};
    logic [2:0] exps[4] = '{3'b101, 3'b100, 3'b011, 3'b010};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'b10, f3s[i], 1'b1, 1'b1, 1'b0, 1'b0);
      step();
      checks += 2;
      if (ALUControl !== exps[i]) begin
        errors++; $display("[TB] FAIL sweep_f3_%b got %b exp %b", f3s[i], ALUControl, exps[i]);
      end
      if (illegal !== 1'b0) begin
        errors++; $display("[TB] FAIL sweep_illegal_%b got %b exp 0", f3s[i], illegal);
      end
    end
  endtask

  task automatic test_aluop_and_bubble();
    drive(1'b1, 2'b01, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    checks++;
    if (ALUControl !== 3'b001) begin errors++; $display("[TB] FAIL aluop01 got %b exp 001", ALUControl); end
    drive(1'b1, 2'b00, 3'b110, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    checks++;
    if (ALUControl !== 3'b000) begin errors++; $display("[TB] FAIL aluop00 got %b exp 000", ALUControl); end
    drive(1'b0, 2'b10, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    checks += 2;
    if (ex_valid !== 1'b0) begin errors++; $display("[TB] FAIL invalid_bubble_valid got %b exp 0", ex_valid); end
    if (ALUControl !== 3'b000) begin errors++; $display("[TB] FAIL invalid_bubble_ctrl got %b exp 000", ALUControl); end
  endtask

  task automatic test_stall_flush();
    drive(1'b1, 2'b01, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 2'b10, 3'b111, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      checks += 2;
      if (ALUControl !== 3'b001) begin errors++; $display("[TB] FAIL stall_hold_%0d got %b exp 001", i, ALUControl); end
      if (ex_valid !== 1'b1) begin errors++; $display("[TB] FAIL stall_valid_%0d got %b exp 1", i, ex_valid); end
    end
    flush = 1'b1;
    step();
    checks += 2;
    if (ex_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_stall_valid got %b exp 0", ex_valid); end
    if (ALUControl !== 3'b000) begin errors++; $display("[TB] FAIL flush_stall_ctrl got %b exp 000", ALUControl); end
    flush = 1'b0; stall = 1'b0;
  endtask

  task automatic test_illegal_stall();
    test_reset();
    drive(1'b1, 2'b11, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    stall = 1'b1;
    for (int i = 0; i < 2; i++) step();
    checks += 2;
    if (ALUControl !== 3'b000) begin errors++; $display("[TB] FAIL illegal_ctrl got %b exp 000", ALUControl); end
    if (ex_valid !== 1'b1) begin errors++; $display("[TB] FAIL illegal_valid got %b exp 1", ex_valid); end
`ifdef ALU_ILLEGAL_TRAP_EN
    checks += 2;
    if (illegal !== 1'b1) begin errors++; $display("[TB] FAIL illegal_flag got %b exp 1", illegal); end
    if (illegal_cnt !== 2'd1) begin errors++; $display("[TB] FAIL illegal_stall_cnt got %0d exp 1", illegal_cnt); end
`else
    checks += 2;
    if (illegal !== 1'b0) begin errors++; $display("[TB] FAIL illegal_tied got %b exp 0", illegal); end
    if (illegal_cnt !== 2'd0) begin errors++; $display("[TB] FAIL cnt_tied got %0d exp 0", illegal_cnt); end
`endif
    // A flushed illegal op never enters EX, so it must not be counted.
    drive(1'b1, 2'b10, 3'b101, 1'b0, 1'b1, 1'b0, 1'b1);
    step();
    checks += 2;
    if (illegal !== 1'b0) begin errors++; $display("[TB] FAIL flush_illegal got %b exp 0", illegal); end
`ifdef ALU_ILLEGAL_TRAP_EN
    if (illegal_cnt !== 2'd1) begin errors++; $display("[TB] FAIL flush_cnt got %0d exp 1", illegal_cnt); end
`else
    if (illegal_cnt !== 2'd0) begin errors++; $display("[TB] FAIL flush_cnt got %0d exp 0", illegal_cnt); end
`endif
    flush = 1'b0;
  endtask

  task automatic test_saturate();
    logic [1:0] exps[5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    logic [2:0] f3s [5] = '{3'b001, 3'b011, 3'b101, 3'b001, 3'b011};
    test_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 2'b10, f3s[i], 1'b0, 1'b1, 1'b0, 1'b0);
      step();
      checks += 2;
      if (ALUControl !== 3'b000) begin errors++; $display("[TB] FAIL sat_ctrl_%0d got %b exp 000", i, ALUControl); end
`ifdef ALU_ILLEGAL_TRAP_EN
      if (illegal_cnt !== exps[i]) begin
        errors++; $display("[TB] FAIL sat_cnt_%0d got %0d exp %0d", i, illegal_cnt, exps[i]);
      end
`else
      if (illegal_cnt !== 2'd0) begin errors++; $display("[TB] FAIL sat_cnt_%0d got %0d exp 0 (exp if trap %0d)", i, illegal_cnt, exps[i]); end
`endif
    end
  endtask

  task automatic test_reset_midop();
    test_reset();
    drive(1'b1, 2'b11, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    step();
    drive(1'b1, 2'b10, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    stall = 1'b1;
    step();
    checks++;
`ifdef ALU_ILLEGAL_TRAP_EN
    if (illegal_cnt !== 2'd2) begin errors++; $display("[TB] FAIL pre_rst_cnt got %0d exp 2", illegal_cnt); end
`else
    if (ALUControl !== 3'b101) begin errors++; $display("[TB] FAIL pre_rst_slt got %b exp 101", ALUControl); end
`endif
    rst = 1'b1;
    step();
    checks += 4;
    if (ex_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_valid got %b exp 0", ex_valid); end
    if (ALUControl !== 3'b000) begin errors++; $display("[TB] FAIL midrst_ctrl got %b exp 000", ALUControl); end
    if (illegal !== 1'b0) begin errors++; $display("[TB] FAIL midrst_illegal got %b exp 0", illegal); end
    if (illegal_cnt !== 2'd0) begin errors++; $display("[TB] FAIL midrst_cnt got %0d exp 0", illegal_cnt); end
    rst = 1'b0;
    drive(1'b1, 2'b10, 3'b100, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    checks += 2;
    if (ex_valid !== 1'b1) begin errors++; $display("[TB] FAIL post_rst_valid got %b exp 1", ex_valid); end
    if (ALUControl !== 3'b100) begin errors++; $display("[TB] FAIL post_rst_ctrl got %b exp 100", ALUControl); end
  endtask

  initial begin
    drive(1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    test_reset();
    test_sub_add();
    test_funct_sweep();
    test_aluop_and_bubble();
    test_stall_flush();
    test_illegal_stall();
    test_saturate();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_decode_stage.md
ALU_DECODE_STAGE -- requirements
Module: alu_decode_stage

Interface
REQ-001 SHALL have parameter: CNT_W, 8, width of illegal-operation counter.
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port: id_valid  input  1  ID-stage holds a valid instruction.
REQ-005 SHALL have port: ALUOp  input  2  main-decoder class (00 add, 01 sub, 10 funct decode, 11 reserved).
REQ-006 SHALL have port: funct3  input  3  instruction funct3.
REQ-007 SHALL have port: funct7b5  input  1  instruction bit 30.
REQ-008 SHALL have port: op5  input  1  opcode bit 5 (1 = R-type, 0 = I-type).
REQ-009 SHALL have port: stall  input  1  hold ID/EX contents.
REQ-010 SHALL have port: flush  input  1  replace ID/EX contents with bubble.
REQ-011 SHALL have port: ex_valid  output  1  registered valid for EX stage.
REQ-012 SHALL have port: ALUControl  output  3  registered ALU operation code for EX stage.
REQ-013 SHALL have port: illegal  output  1  registered flag, EX-stage op unsupported.
REQ-014 SHALL have port: illegal_cnt  output  CNT_W  saturating count of illegal ops entering EX.

Function
REQ-015 SHALL use ALU codes: ADD 000, SUB 001, AND 010, OR 011, XOR 100, SLT 101; codes 110/111 never driven.
REQ-016 SHALL decode ALUOp 00 -> ADD, 01 -> SUB.
REQ-017 SHALL decode ALUOp 10 by funct3: 000 -> SUB if op5&funct7b5 else ADD; 010 -> SLT; 100 -> XOR; 110 -> OR; 111 -> AND.
REQ-018 SHALL classify as illegal: ALUOp 11, or ALUOp 10 with funct3 in {001, 011, 101}; decoded code for illegal ops is ADD.
REQ-019 SHALL register decode result with latency exactly 1 cycle: values present at edge N appear on outputs after edge N.
REQ-020 SHALL, per edge, apply priority rst > flush > stall > load.
REQ-021 SHALL on flush load bubble: ex_valid 0, ALUControl 000, illegal 0; flush with stall simultaneously yields bubble.
REQ-022 SHALL on stall (no flush) hold ex_valid, ALUControl, illegal, illegal_cnt unchanged.
REQ-023 SHALL on load with id_valid 0 load bubble (as REQ-021); decoder inputs ignored.
REQ-024 SHALL on load with id_valid 1 set ex_valid 1, ALUControl and illegal from decode.
REQ-025 SHALL increment illegal_cnt by 1 only on a load with id_valid 1 and illegal decode; saturate at 2^CNT_W-1, no wrap.
REQ-026 SHALL not count a held (stalled) illegal op more than once.

Reset
REQ-027 SHALL on rst high at edge set ex_valid 0, ALUControl 000, illegal 0, illegal_cnt 0, regardless of flush/stall/id_valid.
REQ-028 SHALL discard any in-flight op when rst asserts mid-operation; first load after rst deassert behaves per REQ-024.

Configuration
REQ-029 SHALL honour macro ALU_ILLEGAL_TRAP_EN: defined -> REQ-013, REQ-018 flagging, REQ-025 counting active.
REQ-030 SHALL, with ALU_ILLEGAL_TRAP_EN undefined, still decode illegal ops to ADD with ex_valid 1, tie illegal to 0 and illegal_cnt to 0, and instantiate no counter flops.

Verification
REQ-031 SHALL cover: ALUOp 10, funct3 000, op5 1, funct7b5 1, id_valid 1 -> next cycle ALUControl 001, ex_valid 1; same with op5 0 -> 000.
REQ-032 SHALL cover: sweep ALUOp 10, funct3 010/100/110/111 -> 101/100/011/010 one cycle later, illegal 0.
REQ-033 SHALL cover: valid SUB loaded, then stall 3 cycles with inputs changed to AND -> ALUControl stays 001 for 3 cycles; flush+stall next -> ex_valid 0, ALUControl 000.
REQ-034 SHALL cover (macro defined): ALUOp 11 valid, stalled 2 cycles -> illegal 1, ALUControl 000, illegal_cnt 1 (not 3).
REQ-035 SHALL cover (macro defined, CNT_W 2): 5 consecutive valid illegal loads -> illegal_cnt 1,2,3,3,3.
REQ-036 SHALL cover: rst asserted with flush 0, stall 1, valid SLT held, illegal_cnt 2 -> next cycle all outputs 0; macro undefined -> illegal and illegal_cnt always 0.
